// File: rtl/stage0_feeder.sv
`default_nettype none
// ============================================================================
// Module      : stage0_feeder
// Description : Input sequencer ahead of stage 1. Buffers host {key, data}
//               words in a small circular FIFO, then issues them one at a
//               time over stage 1's ld/start strobes, waiting for stg1_done
//               between words. A watchdog flags a stage 1 that never finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module stage0_feeder #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 16,
  parameter int KEY_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [KEY_W-1:0]         in_key,
  output logic [DATA_W-1:0]        data_out,
  output logic [KEY_W-1:0]         key_out,
  output logic                     ld,
  output logic                     start,
  input  logic                     stg1_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_ent_w = KEY_W + DATA_W;
  localparam int c_wd_w  = $clog2(TIMEOUT + 1);

  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
  localparam logic [c_wd_w-1:0]  c_wd_last = c_wd_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [c_ent_w-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  logic [DATA_W-1:0]    r_data;
  logic [KEY_W-1:0]     r_key;
  logic                 r_ld;
  logic                 r_start;
  logic                 r_busy;
  logic                 r_err;
  logic [c_wd_w-1:0]    r_wd;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_expire;

  // Ready depends only on reset and occupancy, so a full FIFO never accepts
  // a word even if the head is being popped on the same edge.
  assign in_ready = !rst && (r_count != c_full);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  assign w_expire = (r_state == S_WAIT) && !stg1_done && (r_wd == c_wd_last);

  assign data_out = r_data;
  assign key_out  = r_key;
  assign ld       = r_ld;
  assign start    = r_start;
  assign busy     = r_busy;
  assign count    = r_count;
  assign err      = r_err;

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk1) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_key, in_data};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head word is captured on pop and held until the next pop.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_data <= '0;
      r_key  <= '0;
    end else if (w_pop) begin
      {r_key, r_data} <= r_mem[r_rd_ptr];
    end
  end

  // Next-state logic; done outranks watchdog expiry in WAIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (stg1_done)                w_next = S_IDLE;
        else if (r_wd == c_wd_last)   w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus strobes registered from the next state, so ld/start
  // are high exactly while the FSM sits in LOAD/START.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ld    <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ld    <= (w_next == S_LOAD);
      r_start <= (w_next == S_START);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Watchdog counter: cleared while issuing start, counts WAIT cycles.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_wd <= '0;
    end else if (r_state == S_START) begin
      r_wd <= '0;
    end else if ((r_state == S_WAIT) && !stg1_done && (r_wd != c_wd_last)) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage0_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage0_feeder
// Description : Self-checking bench for stage0_feeder. Directed scenarios
//               followed by randomized traffic checked against a queue-based
//               transaction model of the FIFO and issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage0_feeder;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 16;
  localparam int KEY_W   = 5;
  localparam int TIMEOUT = 8;

  logic              clk1 = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [KEY_W-1:0]  in_key;
  logic [DATA_W-1:0] data_out;
  logic [KEY_W-1:0]  key_out;
  logic              ld;
  logic              start;
  logic              stg1_done;
  logic              busy;
  logic [2:0]        count;
  logic              err;

  stage0_feeder #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .KEY_W(KEY_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .data_out(data_out), .key_out(key_out),
    .ld(ld), .start(start), .stg1_done(stg1_done), .busy(busy),
    .count(count), .err(err)
  );

  always #5 clk1 = ~clk1;

  int          n_checks;
  int          n_errors;
  logic [20:0] q[$];        // model FIFO contents, {key, data}
  logic [15:0] issued[$];   // data words seen leaving on ld
  bit          prev_ld;
  bit          ld_seen;
  int          since_ld;
  bit          armed;
  int          wcnt;
  logic [15:0] exp_sp [4] = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were set before the rising edge, outputs are checked at
  // the falling edge against the transaction model.
  task automatic cyc();
    bit          push_now;
    bit          rst_now;
    logic [20:0] wrd;
    logic [20:0] head;
    push_now = !rst && in_valid && (q.size() < DEPTH);
    rst_now  = rst;
    wrd      = {in_key, in_data};
    @(posedge clk1);
    @(negedge clk1);
    since_ld++;
    if (rst_now) begin
      q.delete();
      armed   = 0;
      ld_seen = 0;
      check("rst_ld", ld, 0);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
    end else begin
      if (ld === 1'b1) begin
        check("ld_with_word", q.size() > 0, 1);
        if (q.size() > 0) begin
          head = q.pop_front();
          check("issue_data", data_out, head[15:0]);
          check("issue_key", key_out, head[20:16]);
          issued.push_back(head[15:0]);
        end
        if (ld_seen) check("issue_gap", since_ld >= 4, 1);
        ld_seen  = 1;
        since_ld = 0;
      end
      if (prev_ld) check("start_after_ld", start, 1);
      if (push_now) q.push_back(wrd);
    end
    check("count", count, q.size());
    check("in_ready", in_ready, (!rst && q.size() != DEPTH));
    check("ld_start_excl", ld & start, 0);
    if (ld === 1'b1 || start === 1'b1) check("busy_during_issue", busy, 1);
    prev_ld = (ld === 1'b1) && !rst_now;
  endtask

  // Clock with an automatic stage 1 responder: done comes 0..dmax WAIT
  // cycles after start; optional spurious done outside WAIT.
  task automatic auto_cyc(input int dmax, input bit spur);
    if (armed) begin
      if (wcnt == 0) begin
        stg1_done = 1'b1;
        armed     = 0;
      end else begin
        stg1_done = 1'b0;
        wcnt--;
      end
    end else begin
      stg1_done = spur && ($urandom_range(0, 3) == 0);
    end
    cyc();
    if (start === 1'b1) begin
      armed = 1;
      wcnt  = 1 + $urandom_range(0, dmax);
    end
  endtask

  task automatic drain();
    int guard;
    guard    = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || busy !== 1'b0) && guard < 300) begin
      auto_cyc(2, 0);
      guard++;
    end
    stg1_done = 1'b0;
    check("drain_done", guard < 300, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; stg1_done = 1'b0;
    prev_ld = 0; ld_seen = 0; since_ld = 0; armed = 0; wcnt = 0;

    // Reset then idle
    cyc(); cyc();
    check("rst_data_out", data_out, 0);
    check("rst_key_out", key_out, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_ld", ld, 0);
      check("idle_start", start, 0);
      check("idle_busy", busy, 0);
      check("idle_err", err, 0);
    end

    // Single word with done three cycles after WAIT entry
    in_valid = 1'b1; in_data = 16'hA5C3; in_key = 5'h15;
    cyc();
    check("sw_ld_push_cycle", ld, 0);
    in_valid = 1'b0; in_data = '0; in_key = '0;
    cyc();
    check("sw_ld", ld, 1);
    check("sw_start_early", start, 0);
    check("sw_data", data_out, 16'hA5C3);
    check("sw_key", key_out, 5'h15);
    cyc();
    check("sw_start", start, 1);
    check("sw_ld_late", ld, 0);
    cyc();
    check("sw_wait_busy", busy, 1);
    check("sw_wait_start", start, 0);
    repeat (3) begin
      cyc();
      check("sw_wait_busy", busy, 1);
      check("sw_hold_data", data_out, 16'hA5C3);
    end
    stg1_done = 1'b1;
    cyc();
    stg1_done = 1'b0;
    check("sw_busy_fall", busy, 0);
    repeat (3) begin
      cyc();
      check("sw_hold_data_idle", data_out, 16'hA5C3);
      check("sw_hold_key_idle", key_out, 5'h15);
      check("sw_no_ld", ld, 0);
    end

    // Full FIFO with stage 1 stalled
    issued.delete();
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_data = 16'(k); in_key = 5'(k);
      cyc();
    end
    in_valid = 1'b0;
    check("full_count", count, 4);
    check("full_ready", in_ready, 0);
    check("full_busy", busy, 1);
    check("full_no_ld", ld, 0);
    check("full_no_start", start, 0);
    armed = 1; wcnt = 0;
    drain();
    check("full_issued_n", issued.size(), 5);
    for (int i = 0; i < 5; i++) check("full_order", issued[i], 16'(i + 1));

    // Simultaneous push and pop at count 2
    issued.delete();
    in_valid = 1'b1; in_data = 16'h0A0A; in_key = 5'd1; cyc();
    in_data = 16'h0B0B; in_key = 5'd2; cyc();
    in_data = 16'h0C0C; in_key = 5'd3; cyc();
    in_valid = 1'b0; cyc();
    check("sp_count_wait", count, 2);
    check("sp_busy_wait", busy, 1);
    stg1_done = 1'b1; cyc(); stg1_done = 1'b0;
    check("sp_idle", busy, 0);
    check("sp_count_idle", count, 2);
    in_valid = 1'b1; in_data = 16'h0D0D; in_key = 5'd4; cyc();
    in_valid = 1'b0;
    check("sp_count_hold", count, 2);
    check("sp_ld", ld, 1);
    check("sp_head", data_out, 16'h0B0B);
    drain();
    check("sp_issued_n", issued.size(), 4);
    for (int i = 0; i < 4; i++) check("sp_order", issued[i], exp_sp[i]);

    // Watchdog expiry with stage 1 silent
    in_valid = 1'b1; in_data = 16'h1234; in_key = 5'd7; cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    check("wd_wait_entry", busy, 1);
    for (int i = 1; i < 8; i++) begin
      cyc();
      check("wd_busy", busy, 1);
      check("wd_err_early", err, 0);
    end
    cyc();
    check("wd_idle", busy, 0);
    check("wd_err", err, 1);
    repeat (3) cyc();
    check("wd_err_hold", err, 1);
    issued.delete();
    in_valid = 1'b1; in_data = 16'h4321; in_key = 5'd9; cyc();
    drain();
    check("wd_err_sticky", err, 1);
    check("wd_continue", issued.size() > 0 ? issued[issued.size() - 1] : 16'h0, 16'h4321);

    // Done on the expiry cycle wins over the watchdog
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    check("wd2_err_clear", err, 0);
    in_valid = 1'b1; in_data = 16'h5555; in_key = 5'd3; cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    for (int i = 1; i < 8; i++) cyc();
    check("wd2_still_wait", busy, 1);
    stg1_done = 1'b1; cyc(); stg1_done = 1'b0;
    check("wd2_idle", busy, 0);
    check("wd2_no_err", err, 0);
    cyc();
    check("wd2_no_err_after", err, 0);

    // Reset mid-WAIT with three words buffered
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 16'h0100 + 16'(k); in_key = 5'(k);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("rm_count3", count, 3);
    check("rm_busy_wait", busy, 1);
    rst = 1'b1; cyc();
    check("rm_count0", count, 0);
    check("rm_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("rm_no_ld", ld, 0);
      check("rm_idle", busy, 0);
    end

    // Randomized traffic against the queue model
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      in_key   = 5'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
      auto_cyc(5, 1);
      check("rnd_err", err, 0);
    end
    rst = 1'b0;
    drain();
    check("rnd_empty", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
